// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side engine for the ram1024x8 simple dual-port RAM. A command
//   (start address, byte count) is turned into a run of RAM reads. The
//   returned bytes go through a small FIFO and out on a valid/ready stream.
//   The FIFO is sized so that full throughput is kept despite the RAM read
//   latency.
//
//   Build option: define RAM_RD_OUTREG_EN when the RAM is built with
//   OUTPUT_REG=1. The read latency is then 2 instead of 1, and the FIFO is one
//   entry deeper.
//
// Ports
//   rd_clk, rd_rst         clock and synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_addr first address,
//                          cmd_len byte count (0 legal)
//   ram_rd_addr            registered read address to the RAM
//   ram_rd_data            read data from the RAM (LAT cycles after address)
//   m_data/m_valid/m_ready stream output; m_last marks a command's final beat
//   busy                   command in progress
//   done                   one-cycle pulse when a command completes
//   dbg_state              current FSM state for checkers
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and payload stable until that edge.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

`ifdef RAM_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LD_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LAT-1:0]        tag_v_q, tag_v_d;
  logic [LAT-1:0]        tag_last_q, tag_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];
  logic                  fifo_last_q [DEPTH];
  logic                  fifo_last_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  done_q, done_d;

  logic                  fifo_nonempty;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      inflight;
  logic [LD_W-1:0]       load;
  logic                  credit;
  logic                  issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty && m_ready;
  // The oldest tag has reached the end of the RAM pipe: its data is on
  // ram_rd_data now and is captured at the end of this cycle.
  assign push          = tag_v_q[LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CNT_W'(tag_v_q[i]);
    end
  end

  // A beat leaving this cycle frees its slot before any new read can land
  // (the earliest landing is LAT cycles away), so it is excluded from the
  // load. This is what lets one read per cycle continue while m_ready=1.
  assign load   = LD_W'(count_q) - LD_W'(pop) + LD_W'(inflight);
  assign credit = (load < LD_W'(DEPTH));
  assign issue  = (state_q == S_READ) && credit;

  // Next-state and command/address logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = pop && m_last;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len != '0) state_d = S_READ;
          else               done_d  = 1'b1;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight == '0 && !fifo_nonempty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight tag pipe and output FIFO
  always_comb begin
    tag_v_d       = '0;
    tag_last_d    = '0;
    tag_v_d[0]    = issue;
    tag_last_d[0] = issue && (rem_q == LEN_WIDTH'(1));
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]    = tag_v_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end

    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_data_d[wr_ptr_q] = ram_rd_data;
      fifo_last_d[wr_ptr_q] = tag_last_q[LAT-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      tag_v_q    <= '0;
      tag_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      tag_v_q     <= tag_v_d;
      tag_last_q  <= tag_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // The address register doubles as the read pointer: in READ the RAM is
  // reading addr_q in the current cycle whether or not a tag is issued. Reads
  // without a tag are simply discarded.
  assign ram_rd_addr = addr_q;
  assign cmd_ready   = (state_q == S_IDLE) && !rd_rst;
  assign m_valid     = fifo_nonempty;
  assign m_data      = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last      = fifo_nonempty && fifo_last_q[rd_ptr_q];
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader. It models the RAM (latency 1, or 2 when
// RAM_RD_OUTREG_EN is defined) and predicts every command's byte stream from
// the RAM contents: byte i comes from mem[(addr+i) mod 1024], and the last
// byte carries m_last. Directed cases come first, then randomized commands
// under random back-pressure.
module tb_ram_stream_reader;

`ifdef RAM_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Clock and reset
  logic        clk = 1'b0;
  logic        rd_rst;
  always #5 clk = ~clk;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [9:0]  ram_rd_addr;
  logic [7:0]  ram_rd_data;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  ram_stream_reader dut (
    .rd_clk     (clk),
    .rd_rst     (rd_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // RAM model
  logic [7:0] mem [1024];
`ifdef RAM_RD_OUTREG_EN
  logic [7:0] ram_s1;
  always @(posedge clk) begin
    ram_s1      <= mem[ram_rd_addr];
    ram_rd_data <= ram_s1;
  end
`else
  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: {last, data}
  logic [8:0] exp_q [$];
  int         beat_cyc [$];
  int         total = 0;
  int         bad = 0;
  int         beat_n = 0;
  int         done_cnt = 0;
  int         ready_mode = 0;  // 0: always 1, 1: 1,0,0 repeating, 2: random
  int         rdy_ph = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Consumer ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = (rdy_ph % 3 == 0); rdy_ph++; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: beats against the expected queue, payload stability
  // under stall, and the done pulse exactly one cycle after completion.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;
  logic       done_pend = 1'b0;
  always @(negedge clk) begin
    if (rd_rst) begin
      prev_stall = 1'b0;
      done_pend  = 1'b0;
    end else begin
      check_eq("done_timing", done, done_pend);
      if (done) done_cnt++;
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_payload", {m_last, m_data}, prev_beat);
      end
      if (m_valid && m_ready) begin
        beat_n++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) check_eq("extra_beat", {m_last, m_data}, 32'hFFFF_FFFF);
        else check_eq("beat", {m_last, m_data}, exp_q.pop_front());
      end
      done_pend  = (m_valid && m_ready && m_last) || (cmd_valid && cmd_ready && cmd_len == 11'd0);
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  // Driver tasks
  task automatic send_cmd(input logic [9:0] addr, input int len);
    logic [9:0] a;
    int         n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = 11'(len);
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 5000) begin
        check_eq("cmd_accept_timeout", 0, 1);
        break;
      end
    end
    for (int i = 0; i < len; i++) begin
      a = addr + 10'(i);
      exp_q.push_back({(i == len - 1), mem[a]});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      n++;
      if (n > 5000) begin
        check_eq(tag, 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
  endtask

  initial begin
    int         n;
    int         d0;
    int         b0;
    int         len;
    int         sum_len;
    logic [9:0] a;

    rd_rst    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    load_ramp();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    rd_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready_idle", cmd_ready, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ram_rd_addr", ram_rd_addr, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_m_last", m_last, 0);

    // Basic run at full rate: first beat LAT+1 edges after the handshake
    // edge, beats back to back, one done pulse.
    ready_mode = 0;
    beat_cyc.delete();
    d0 = done_cnt;
    send_cmd(10'h010, 4);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (m_valid || n > 20) break;
    end
    check_eq("first_beat_latency", n - 1, LAT + 1);
    wait_idle("t1_timeout");
    check_eq("t1_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check_eq("t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
    check_eq("t1_done_count", done_cnt - d0, 1);

    // Address wrap: RAM sees 3FE, 3FF, 000, 001 on consecutive cycles.
    send_cmd(10'h3FE, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 10'h3FE + 10'(i);
      check_eq("wrap_rd_addr", ram_rd_addr, a);
    end
    wait_idle("t2_timeout");

    // Back-pressure with the 1,0,0 ready pattern.
    ready_mode = 1;
    rdy_ph     = 0;
    b0         = beat_n;
    d0         = done_cnt;
    send_cmd(10'h020, 8);
    wait_idle("t3_timeout");
    check_eq("t3_beats", beat_n - b0, 8);
    check_eq("t3_done_count", done_cnt - d0, 1);
    ready_mode = 0;

    // Zero length: no data, single done, ready again at once.
    b0 = beat_n;
    d0 = done_cnt;
    send_cmd(10'h055, 0);
    @(negedge clk);
    check_eq("len0_cmd_ready", cmd_ready, 1);
    check_eq("len0_busy", busy, 0);
    repeat (4) begin
      @(negedge clk);
      check_eq("len0_no_valid", m_valid, 0);
    end
    check_eq("len0_done_count", done_cnt - d0, 1);
    check_eq("len0_beats", beat_n - b0, 0);

    // Reset after the third beat of a 16-byte command.
    b0 = beat_n;
    send_cmd(10'h100, 16);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      if (beat_n >= b0 + 3 || n > 100) break;
    end
    #1;
    rd_rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rd_rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_m_valid", m_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check_eq("midrst_quiet", m_valid, 0);
    end
    b0 = beat_n;
    send_cmd(10'h000, 2);
    wait_idle("t5_timeout");
    repeat (3) @(posedge clk);
    check_eq("t5_beats", beat_n - b0, 2);

    // Randomized commands over random RAM contents and random ready, with
    // ignored commands offered while busy.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    ready_mode = 2;
    b0         = beat_n;
    d0         = done_cnt;
    sum_len    = 0;
    for (int k = 0; k < 25; k++) begin
      len = (k == 12) ? 1024 : $urandom_range(0, 48);
      sum_len += len;
      send_cmd(10'($urandom_range(0, 1023)), len);
      if (len >= 8) begin
        for (int j = 0; j < 2; j++) begin
          #1;
          if (busy) begin
            cmd_valid = 1'b1;
            cmd_addr  = 10'($urandom_range(0, 1023));
            cmd_len   = 11'($urandom_range(1, 9));
            @(negedge clk);
            if (busy) check_eq("busy_cmd_ready", cmd_ready, 0);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
          end
        end
      end
      wait_idle("rand_timeout");
    end
    repeat (3) @(posedge clk);
    check_eq("rand_beats", beat_n - b0, sum_len);
    check_eq("rand_done_count", done_cnt - d0, 25);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
